// File: rtl/wb_slave_mux_if.sv
// Bus bundle between the processor-side Wishbone master, the slave mux
// and the register slaves behind it.
//
// Handshake: a request is presented while cyc & stb are high and is held
// until the mux answers with a single-cycle ack or err; dropping cyc before
// that abandons the request and no answer follows. On the slave side the
// mux holds one cyc/stb bit high until that slave raises ack or err (or the
// mux gives up); ack/err from any other slave is ignored.
interface wb_slave_mux_if #(
  parameter int NUM_SLAVES = 4
);
  logic                       wbm_cyc_i;
  logic                       wbm_stb_i;
  logic                       wbm_we_i;
  logic [3:0]                 wbm_sel_i;
  logic [31:0]                wbm_adr_i;
  logic [31:0]                wbm_dat_i;
  logic [31:0]                wbm_dat_o;
  logic                       wbm_ack_o;
  logic                       wbm_err_o;
  logic [NUM_SLAVES-1:0]      wbs_cyc_o;
  logic [NUM_SLAVES-1:0]      wbs_stb_o;
  logic                       wbs_we_o;
  logic [3:0]                 wbs_sel_o;
  logic [31:0]                wbs_adr_o;
  logic [31:0]                wbs_dat_o;
  logic [32*NUM_SLAVES-1:0]   wbs_dat_i;
  logic [NUM_SLAVES-1:0]      wbs_ack_i;
  logic [NUM_SLAVES-1:0]      wbs_err_i;

  // Environment view: drives the master request and the slave replies.
  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i
  );

  // Mux view: slave to the processor, master to the register slaves.
  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i
  );
endinterface

// File: rtl/wb_slave_mux.sv
// Single-master to NUM_SLAVES Wishbone address decoder and router.
// Registers the request, strobes the slave whose window contains the
// address, and returns its data/ack/err. Unmapped addresses and slaves that
// stay silent for TIMEOUT_CYCLES cycles are answered with err.
module wb_slave_mux #(
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]  C_BASEADDRS    = {32'h00030000, 32'h00020000,
                                                         32'h00010000, 32'h00000000},
  parameter logic [32*NUM_SLAVES-1:0]  C_HIGHADDRS    = {32'h0003FFFF, 32'h0002FFFF,
                                                         32'h0001FFFF, 32'h0000FFFF},
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_slave_mux_if.slave     bus,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       sel_idx;
  logic [7:0]             cnt;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [NUM_SLAVES-1:0]  hit_onehot;
  logic                   sel_ack;
  logic                   sel_err;
  logic [31:0]            sel_dat;

  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

  // Window decode of the incoming address; scanning downwards lets the
  // lowest matching index win when windows overlap.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (bus.wbm_adr_i >= C_BASEADDRS[32*k +: 32] &&
          bus.wbm_adr_i <= C_HIGHADDRS[32*k +: 32]) begin
        hit           = 1'b1;
        hit_idx       = IDX_W'(k);
        hit_onehot    = '0;
        hit_onehot[k] = 1'b1;
      end
    end
  end

  // Pick out the reply lines of the slave that owns the current transfer.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (IDX_W'(k) == sel_idx) begin
        sel_ack = bus.wbs_ack_i[k];
        sel_err = bus.wbs_err_i[k];
        sel_dat = bus.wbs_dat_i[32*k +: 32];
      end
    end
  end

  // Transfer FSM; all bus outputs are registered here. ack/err default low
  // so each response is exactly one cycle wide.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state         <= IDLE;
      sel_idx       <= '0;
      cnt           <= '0;
      bus.wbm_dat_o <= '0;
      bus.wbm_ack_o <= 1'b0;
      bus.wbm_err_o <= 1'b0;
      bus.wbs_cyc_o <= '0;
      bus.wbs_stb_o <= '0;
      bus.wbs_we_o  <= 1'b0;
      bus.wbs_sel_o <= '0;
      bus.wbs_adr_o <= '0;
      bus.wbs_dat_o <= '0;
    end else begin
      bus.wbm_ack_o <= 1'b0;
      bus.wbm_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
            bus.wbs_we_o  <= bus.wbm_we_i;
            bus.wbs_sel_o <= bus.wbm_sel_i;
            bus.wbs_adr_o <= bus.wbm_adr_i;
            bus.wbs_dat_o <= bus.wbm_dat_i;
            cnt           <= '0;
            if (hit) begin
              sel_idx       <= hit_idx;
              bus.wbs_cyc_o <= hit_onehot;
              bus.wbs_stb_o <= hit_onehot;
              state         <= ACTIVE;
            end else begin
              bus.wbm_err_o <= 1'b1;
              state         <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!bus.wbm_cyc_i) begin
            // Master walked away: release the slave silently.
            bus.wbs_cyc_o <= '0;
            bus.wbs_stb_o <= '0;
            cnt           <= '0;
            state         <= IDLE;
          end else if (sel_err) begin
            bus.wbs_cyc_o <= '0;
            bus.wbs_stb_o <= '0;
            cnt           <= '0;
            bus.wbm_err_o <= 1'b1;
            state         <= RESP;
          end else if (sel_ack) begin
            bus.wbs_cyc_o <= '0;
            bus.wbs_stb_o <= '0;
            cnt           <= '0;
            if (!bus.wbs_we_o) bus.wbm_dat_o <= sel_dat;
            bus.wbm_ack_o <= 1'b1;
            state         <= RESP;
          end else if (cnt == TO_LAST) begin
            bus.wbs_cyc_o <= '0;
            bus.wbs_stb_o <= '0;
            cnt           <= '0;
            bus.wbm_err_o <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: directed vector table, hand-written sequences for
// reset/abort/back-to-back, and randomized transfers against a window/timing
// reference model.
module tb_wb_slave_mux;

  localparam int NS = 4;
  localparam int TO = 16;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_slave_mux_if #(.NUM_SLAVES(NS)) bus ();
  logic       busy;
  logic [1:0] dbg_state;

  wb_slave_mux #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .bus         (bus),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] base_a [NS] = '{32'h00000000, 32'h00010000, 32'h00020000, 32'h00030000};
  logic [31:0] high_a [NS] = '{32'h0000FFFF, 32'h0001FFFF, 32'h0002FFFF, 32'h0003FFFF};
  logic [31:0] sdat   [NS];
  logic [31:0] exp_dat;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          kind;
    int          w;
    logic        exp_ack;
    int          exp_edge;
    logic [3:0]  exp_stb;
    int          exp_cnt;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vt [12];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Address window lookup, lowest index first.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if (a >= base_a[k] && a <= high_a[k]) return k;
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Presents one request and plays the slaves. The addressed slave answers
  // w cycles after a zero-wait slave would; others are driven with noise.
  task automatic run_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int w, input bit rnd_noise,
                          output int r_ack, output int r_err, output int r_edge, output int r_cnt,
                          output int r_both, output int r_cycbad, output logic [3:0] r_or);
    int tgt;
    int seen;
    bit done;
    logic [NS-1:0] ack_v;
    logic [NS-1:0] err_v;
    tgt = decode(adr);
    r_ack = 0; r_err = 0; r_edge = -1; r_cnt = 0; r_both = 0; r_cycbad = 0; r_or = '0;
    seen = 0; done = 1'b0;
    for (int k = 0; k < NS; k++) bus.wbs_dat_i[32*k +: 32] = sdat[k];
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_we_i  = we;
    bus.wbm_sel_i = sel;
    bus.wbm_adr_i = adr;
    bus.wbm_dat_i = dat;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wbs_stb_o != '0) begin
        r_cnt++;
        r_or = r_or | bus.wbs_stb_o;
      end
      if (bus.wbs_cyc_o !== bus.wbs_stb_o) r_cycbad++;
      if (bus.wbm_ack_o) r_ack++;
      if (bus.wbm_err_o) r_err++;
      if (bus.wbm_ack_o && bus.wbm_err_o) r_both++;
      if ((bus.wbm_ack_o || bus.wbm_err_o) && r_edge < 0) begin
        r_edge = i;
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
      end
      if (tgt >= 0 && bus.wbs_stb_o[tgt]) seen++;
      ack_v = '0;
      err_v = '0;
      for (int k = 0; k < NS; k++) begin
        if (k != tgt) begin
          if (rnd_noise) begin
            ack_v[k] = 1'($urandom_range(0, 1));
            err_v[k] = 1'($urandom_range(0, 1));
          end else begin
            ack_v[k] = 1'b1;
          end
        end
      end
      if (tgt >= 0 && bus.wbs_stb_o[tgt] && seen >= 2 + w) begin
        ack_v[tgt] = (kind == K_ACK || kind == K_BOTH);
        err_v[tgt] = (kind == K_ERR || kind == K_BOTH);
      end
      bus.wbs_ack_i = ack_v;
      bus.wbs_err_i = err_v;
      if (r_edge >= 0 && i >= r_edge + 3) done = 1'b1;
    end
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
  endtask

  task automatic xfer_check(input string tag, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input int kind, input int w, input bit rnd_noise,
                            input logic exp_ack, input int exp_edge, input logic [3:0] exp_stb,
                            input int exp_cnt, input logic [31:0] xdat);
    int r_ack, r_err, r_edge, r_cnt, r_both, r_cycbad;
    logic [3:0] r_or;
    logic [3:0] sel;
    sel = 4'($urandom_range(0, 15));
    run_xfer(we, adr, dat, sel, kind, w, rnd_noise, r_ack, r_err, r_edge, r_cnt, r_both, r_cycbad, r_or);
    check({tag, "_ack"},    r_ack, exp_ack ? 32'd1 : 32'd0);
    check({tag, "_err"},    r_err, exp_ack ? 32'd0 : 32'd1);
    check({tag, "_edge"},   r_edge, exp_edge);
    check({tag, "_stb"},    32'(r_or), 32'(exp_stb));
    check({tag, "_stbcnt"}, r_cnt, exp_cnt);
    check({tag, "_both"},   r_both, 32'd0);
    check({tag, "_cyc"},    r_cycbad, 32'd0);
    check({tag, "_rdat"},   bus.wbm_dat_o, xdat);
    check({tag, "_adr"},    bus.wbs_adr_o, adr);
    check({tag, "_wdat"},   bus.wbs_dat_o, dat);
    check({tag, "_we"},     32'(bus.wbs_we_o), 32'(we));
    check({tag, "_sel"},    32'(bus.wbs_sel_o), 32'(sel));
  endtask

  // ---------------- main test ----------------
  initial begin
    int acc;
    int nack, e0, e1, run;
    vt[0]  = '{1'b1, 32'h00010004, 32'hEEEEEEEE, K_ACK,  0,  1'b1, 2,  4'b0010, 2,  32'h00000000};
    vt[1]  = '{1'b0, 32'h00020000, 32'h00000000, K_ACK,  0,  1'b1, 2,  4'b0100, 2,  32'hDEADBEEF};
    vt[2]  = '{1'b0, 32'h00040000, 32'h00000000, K_ACK,  0,  1'b0, 0,  4'b0000, 0,  32'hDEADBEEF};
    vt[3]  = '{1'b0, 32'h00030000, 32'h00000000, K_NONE, 0,  1'b0, 16, 4'b1000, 16, 32'hDEADBEEF};
    vt[4]  = '{1'b0, 32'h00000000, 32'h00000000, K_BOTH, 0,  1'b0, 2,  4'b0001, 2,  32'hDEADBEEF};
    vt[5]  = '{1'b0, 32'h0000FFFF, 32'h00000000, K_ACK,  3,  1'b1, 5,  4'b0001, 5,  32'h12345678};
    vt[6]  = '{1'b0, 32'h0003FFFF, 32'h00000000, K_ACK,  14, 1'b1, 16, 4'b1000, 16, 32'h33333333};
    vt[7]  = '{1'b0, 32'h0001FFFF, 32'h00000000, K_ACK,  15, 1'b0, 16, 4'b0010, 16, 32'h33333333};
    vt[8]  = '{1'b0, 32'hFFFFFFFF, 32'h00000000, K_ACK,  0,  1'b0, 0,  4'b0000, 0,  32'h33333333};
    vt[9]  = '{1'b0, 32'h00010000, 32'h00000000, K_ERR,  2,  1'b0, 4,  4'b0010, 4,  32'h33333333};
    vt[10] = '{1'b1, 32'h00020010, 32'hA5A5F00F, K_ACK,  1,  1'b1, 3,  4'b0100, 3,  32'h33333333};
    vt[11] = '{1'b0, 32'h00010000, 32'h00000000, K_ACK,  0,  1'b1, 2,  4'b0010, 2,  32'h11111111};

    rst_n = 1'b0;
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbm_we_i = 1'b0;
    bus.wbm_sel_i = '0;   bus.wbm_adr_i = '0;   bus.wbm_dat_i = '0;
    bus.wbs_dat_i = '0;   bus.wbs_ack_i = '0;   bus.wbs_err_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack",  32'(bus.wbm_ack_o), 32'd0);
    check("rst_err",  32'(bus.wbm_err_o), 32'd0);
    check("rst_rdat", bus.wbm_dat_o, 32'd0);
    check("rst_stb",  32'(bus.wbs_stb_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    sdat[0] = 32'h12345678; sdat[1] = 32'h11111111;
    sdat[2] = 32'hDEADBEEF; sdat[3] = 32'h33333333;
    for (int v = 0; v < 12; v++)
      xfer_check($sformatf("vec%0d", v), vt[v].we, vt[v].adr, vt[v].dat, vt[v].kind, vt[v].w,
                 1'b0, vt[v].exp_ack, vt[v].exp_edge, vt[v].exp_stb, vt[v].exp_cnt, vt[v].exp_dat);

    // Asynchronous reset in the middle of an ACTIVE transfer
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = 1'b0;
    bus.wbm_adr_i = 32'h00030040;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_stb",  32'(bus.wbs_stb_o), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stb",  32'(bus.wbs_stb_o), 32'd0);
    check("arst_cyc",  32'(bus.wbs_cyc_o), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdat", bus.wbm_dat_o, 32'd0);
    check("arst_adr",  bus.wbs_adr_o, 32'd0);
    check("arst_resp", 32'({bus.wbm_ack_o, bus.wbm_err_o}), 32'd0);
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wbm_ack_o || bus.wbm_err_o || busy) acc++;
    end
    check("arst_after", acc, 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    exp_dat = 32'h0;

    // Master abort while ACTIVE
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = 1'b0;
    bus.wbm_adr_i = 32'h00010008;
    repeat (3) @(negedge clk);
    check("abort_stb_pre", 32'(bus.wbs_stb_o), 32'h2);
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stb",  32'(bus.wbs_stb_o), 32'd0);
    acc = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wbm_ack_o || bus.wbm_err_o) acc++;
    end
    check("abort_resp", acc, 32'd0);

    // Back-to-back reads with stb held: responses four cycles apart
    sdat[0] = 32'hCAFE0001;
    bus.wbs_dat_i[31:0] = sdat[0];
    bus.wbm_cyc_i = 1'b1; bus.wbm_stb_i = 1'b1; bus.wbm_we_i = 1'b0;
    bus.wbm_adr_i = 32'h00000100;
    nack = 0; e0 = -1; e1 = -1; run = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.wbm_ack_o) begin
        nack++;
        if (e0 < 0) e0 = i;
        else if (e1 < 0) e1 = i;
      end
      if (bus.wbs_stb_o[0]) run++;
      else run = 0;
      bus.wbs_ack_i[0] = (run >= 2);
    end
    bus.wbm_cyc_i = 1'b0; bus.wbm_stb_i = 1'b0; bus.wbs_ack_i = '0;
    repeat (3) @(negedge clk);
    check("b2b_count", nack, 32'd2);
    check("b2b_first", e0, 32'd2);
    check("b2b_second", e1, 32'd6);
    check("b2b_rdat", bus.wbm_dat_o, 32'hCAFE0001);
    exp_dat = 32'hCAFE0001;

    // Randomized transfers against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] adr, dat;
      logic we, mexp_ack;
      int kind, w, tgt, medge, mcnt, r;
      logic [3:0] mstb;
      r = $urandom_range(0, 4);
      if (r < 4) adr = base_a[r] + 32'($urandom_range(0, 32'h0000FFFF));
      else       adr = 32'h00040000 + 32'($urandom_range(0, 32'hFFFBFFFF));
      dat  = $urandom;
      we   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      w    = $urandom_range(0, 17);
      for (int k = 0; k < NS; k++) sdat[k] = $urandom;
      tgt = decode(adr);
      if (tgt < 0) begin
        mexp_ack = 1'b0; medge = 0; mcnt = 0; mstb = '0;
      end else begin
        mstb = 4'(1 << tgt);
        if (kind == K_NONE || 2 + w > TO) begin
          mexp_ack = 1'b0; medge = TO; mcnt = TO;
        end else begin
          mexp_ack = (kind == K_ACK); medge = 2 + w; mcnt = 2 + w;
        end
        if (mexp_ack && !we) exp_dat = sdat[tgt];
      end
      exp_q.push_back(exp_dat);
      xfer_check($sformatf("rnd%0d", n), we, adr, dat, kind, w, 1'b1,
                 mexp_ack, medge, mstb, mcnt, exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/wb_slave_mux.md
Name: wb_slave_mux

Overview:
- Single-master to N-slave Wishbone address decoder and router.
- Sits directly upstream of the sw_reg slaves, between the processor-side bus master and the register slaves; each sw_reg instance connects to one slave port.
- Registers the request, selects one slave by address window, and returns that slave's data, ack or err to the master.
- Generates err for unmapped addresses and for slaves that do not respond in time.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- C_BASEADDRS, {32'h00030000,32'h00020000,32'h00010000,32'h00000000}, packed 32*NUM_SLAVES base addresses; slave k uses bits [32k+31:32k].
- C_HIGHADDRS, {32'h0003FFFF,32'h0002FFFF,32'h0001FFFF,32'h0000FFFF}, packed inclusive high addresses, same packing.
- TIMEOUT_CYCLES, 16, cycles in ACTIVE without slave ack/err before timeout err (1..255).

Ports:
- wb_clk_i  in  1  bus clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_we_i  in  1  master write enable.
- wbm_sel_i  in  4  master byte selects.
- wbm_adr_i  in  32  master address.
- wbm_dat_i  in  32  master write data.
- wbm_dat_o  out  32  read data to master.
- wbm_ack_o  out  1  transfer complete.
- wbm_err_o  out  1  transfer error.
- wbs_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot or zero.
- wbs_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot or zero.
- wbs_we_o  out  1  shared write enable.
- wbs_sel_o  out  4  shared byte selects.
- wbs_adr_o  out  32  shared address (full, not offset).
- wbs_dat_o  out  32  shared write data.
- wbs_dat_i  in  32*NUM_SLAVES  packed slave read data.
- wbs_ack_i  in  NUM_SLAVES  slave acks.
- wbs_err_i  in  NUM_SLAVES  slave errs.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (wb_rst_i=0, asynchronous): FSM to IDLE; every output, including wbm_dat_o, clears to 0; timeout counter clears to 0. Reset asserted mid-transaction aborts it with no ack or err.
- Address hit for slave k: C_BASEADDRS[k] <= adr <= C_HIGHADDRS[k]. If windows overlap, the lowest index wins.
- IDLE: when wbm_cyc_i & wbm_stb_i are both high, latch we/sel/adr/dat and decode.
  - Hit on slave k: store k, go to ACTIVE, drive wbs_cyc_o[k] and wbs_stb_o[k] high from the next edge.
  - No hit: go to RESP with err.
- ACTIVE: counter increments each cycle.
  - Selected slave's err: go to RESP with err.
  - Else selected slave's ack: capture wbs_dat_i slice k into wbm_dat_o if the transfer is a read; writes leave wbm_dat_o unchanged. Go to RESP with ack.
  - Else counter reaches TIMEOUT_CYCLES: go to RESP with err.
  - Same-cycle priority: slave err > slave ack > timeout.
  - ack and err from non-selected slaves are ignored.
  - On any exit from ACTIVE, wbs_cyc_o and wbs_stb_o drop to 0 and the counter clears.
- RESP: wbm_ack_o or wbm_err_o is high for exactly one cycle, never both. Then go to IDLE.
- Master abort: wbm_cyc_i low in ACTIVE returns the FSM to IDLE next edge, drops slave strobes, and generates no ack or err.
- Back-to-back: a master holding stb after its ack is accepted as a new request in IDLE. Minimum spacing between master responses is 4 cycles.
- Latency, zero-wait slave (ack one cycle after seeing stb):
  - edge 0: request sampled in IDLE.
  - edge 1: slave stb high.
  - edge 2: slave ack sampled.
  - edge 3: wbm_ack_o high.
- Unmapped address: wbm_err_o is high after edge 1; no slave strobe is ever asserted.
- wbs_we_o, wbs_sel_o, wbs_adr_o and wbs_dat_o hold the latched values until the next request is accepted.

Test Plan:
- Reset with wb_rst_i=0 mid-ACTIVE, no clock edge -> all outputs 0 immediately; after release, busy_o=0.
- Write adr 32'h00010004, dat 32'hEEEEEEEE, slave1 acks 1 cycle after stb -> wbs_stb_o=4'b0010 with wbs_dat_o=32'hEEEEEEEE; wbm_ack_o pulses at edge 3; wbm_dat_o unchanged.
- Read adr 32'h00020000, slave2 returns 32'hDEADBEEF -> wbm_dat_o=32'hDEADBEEF with a one-cycle wbm_ack_o; slave0 data 32'h12345678 is not selected.
- Read adr 32'h00040000 (unmapped) -> wbs_stb_o stays 0; wbm_err_o is a single-cycle pulse; no ack.
- Slave3 never acks with TIMEOUT_CYCLES=16 -> wbs_stb_o[3] is high for 16 cycles, then drops; wbm_err_o pulses once.
- Same-cycle ack+err from slave0 -> wbm_err_o only. Ack from unselected slave1 while slave0 is selected -> ignored. wbm_cyc_i dropped in ACTIVE -> no response and busy_o=0 on the next cycle.
